// File: rtl/posit_cop_master.sv
// Bus initiator for the posit coprocessor: runs write A, write B, write opcode, read result per command.
// Optional macro POSIT_COP_MASTER_TIMEOUT_EN aborts a bus wait after TIMEOUT cycles with an error response.
module posit_cop_master #(
  parameter int          N         = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          TIMEOUT   = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [N-1:0] cmd_a_i,
  input  logic [N-1:0] cmd_b_i,
  input  logic [2:0]   cmd_op_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [31:0]  rsp_data_o,
  output logic         rsp_err_o,
  output logic         conv_req_o,
  output logic         conv_we_o,
  output logic [3:0]   conv_be_o,
  output logic [31:0]  conv_addr_o,
  output logic [31:0]  conv_wdata_o,
  input  logic         conv_rvalid_i,
  input  logic [31:0]  conv_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_OP, RD, WAIT, RESP} state_e;

  // Tag held during WAIT naming the step that follows the outstanding response.
  localparam logic [1:0] NXT_B    = 2'd0;
  localparam logic [1:0] NXT_OP   = 2'd1;
  localparam logic [1:0] NXT_RD   = 2'd2;
  localparam logic [1:0] NXT_DONE = 2'd3;

  state_e        state_q;
  logic [1:0]    nxt_q;
  logic [N-1:0]  b_q;
  logic [2:0]    op_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;
  logic          req_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
`ifdef POSIT_COP_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]    cnt_q;
`endif

  // Command sequencer; bus outputs are loaded on the edge that enters each issue state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      nxt_q       <= NXT_B;
      b_q         <= '0;
      op_q        <= 3'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
`ifdef POSIT_COP_MASTER_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      case (state_q)
        IDLE: begin
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            b_q         <= cmd_b_i;
            op_q        <= cmd_op_i;
            if (cmd_op_i == 3'd1 || cmd_op_i == 3'd2 || cmd_op_i == 3'd3) begin
              state_q <= WR_A;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              be_q    <= 4'hF;
              addr_q  <= BASE_ADDR;
              wdata_q <= 32'(cmd_a_i);
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'd0;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WR_A, WR_B, WR_OP, RD: begin
          state_q <= WAIT;
`ifdef POSIT_COP_MASTER_TIMEOUT_EN
          cnt_q   <= 8'd0;
`endif
          case (state_q)
            WR_A:    nxt_q <= NXT_B;
            WR_B:    nxt_q <= NXT_OP;
            WR_OP:   nxt_q <= NXT_RD;
            default: nxt_q <= NXT_DONE;
          endcase
        end
        WAIT: begin
          if (conv_rvalid_i) begin
            case (nxt_q)
              NXT_B: begin
                state_q <= WR_B;
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                be_q    <= 4'hF;
                addr_q  <= BASE_ADDR + 32'd8;
                wdata_q <= 32'(b_q);
              end
              NXT_OP: begin
                state_q <= WR_OP;
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                be_q    <= 4'hF;
                addr_q  <= BASE_ADDR + 32'd16;
                wdata_q <= {29'd0, op_q};
              end
              NXT_RD: begin
                state_q <= RD;
                req_q   <= 1'b1;
                be_q    <= 4'hF;
                addr_q  <= BASE_ADDR + 32'd16;
              end
              default: begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rsp_data_q  <= conv_rdata_i;
              end
            endcase
          end
`ifdef POSIT_COP_MASTER_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 32'hDEAD_0000 | {29'd0, op_q};
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign conv_req_o   = req_q;
  assign conv_we_o    = we_q;
  assign conv_be_o    = be_q;
  assign conv_addr_o  = addr_q;
  assign conv_wdata_o = wdata_q;

endmodule

// File: tb/tb_posit_cop_master.sv
// Scoreboard bench for posit_cop_master: bus and response expectations are queued at command drive time.
module tb_posit_cop_master;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [N-1:0] cmd_a_i = '0;
  logic [N-1:0] cmd_b_i = '0;
  logic [2:0]   cmd_op_i = 3'd0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [31:0]  rsp_data_o;
  logic         rsp_err_o;
  logic         conv_req_o;
  logic         conv_we_o;
  logic [3:0]   conv_be_o;
  logic [31:0]  conv_addr_o;
  logic [31:0]  conv_wdata_o;
  logic         conv_rvalid_i;
  logic [31:0]  conv_rdata_i;

  logic         slv_rv = 1'b0;
  logic         spur_rv = 1'b0;
  logic [31:0]  slv_rdata = 32'd0;
  logic [31:0]  slv_rdval = 32'd0;
  int           slv_delay = 0;
  logic         drop_op = 1'b0;
  int           req_cnt = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  logic [64:0]  bus_q[$];
  logic [32:0]  rsp_q[$];

  assign conv_rvalid_i = slv_rv | spur_rv;
  assign conv_rdata_i  = slv_rdata;

  always #5 clk = ~clk;

  posit_cop_master #(.N(N), .BASE_ADDR(32'h0), .TIMEOUT(10)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .conv_req_o(conv_req_o), .conv_we_o(conv_we_o), .conv_be_o(conv_be_o),
    .conv_addr_o(conv_addr_o), .conv_wdata_o(conv_wdata_o),
    .conv_rvalid_i(conv_rvalid_i), .conv_rdata_i(conv_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every request must match the next queued transaction.
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (conv_req_o) begin
        req_cnt++;
        if (bus_q.size() == 0) begin
          check_eq("bus_unexpected_req", {conv_we_o, conv_addr_o, conv_wdata_o}, 65'd0);
        end else begin
          e = bus_q.pop_front();
          check_eq("bus_txn", {conv_we_o, conv_addr_o, conv_wdata_o}, e);
          check_eq("bus_be", 65'(conv_be_o), 65'hF);
        end
      end
    end
  end

  // Slave: answers each request after slv_delay extra cycles; write responses carry junk read data.
  initial begin
    logic we;
    logic [31:0] addr;
    logic drop;
    forever begin
      @(negedge clk);
      if (conv_req_o && rst_ni) begin
        we   = conv_we_o;
        addr = conv_addr_o;
        drop = drop_op && we && (addr == 32'd16);
        @(posedge clk);
        repeat (slv_delay) @(posedge clk);
        #1;
        if (!drop) begin
          slv_rv    = 1'b1;
          slv_rdata = we ? 32'hFFFF_FFFF : slv_rdval;
        end
        @(posedge clk);
        #1;
        slv_rv    = 1'b0;
        slv_rdata = 32'd0;
      end
    end
  end

  task automatic expect_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                            input logic [31:0] rd);
    if (op >= 3'd1 && op <= 3'd3) begin
      bus_q.push_back({1'b1, 32'd0,  32'(a)});
      bus_q.push_back({1'b1, 32'd8,  32'(b)});
      bus_q.push_back({1'b1, 32'd16, {29'd0, op}});
      bus_q.push_back({1'b0, 32'd16, 32'd0});
      rsp_q.push_back({1'b0, rd});
    end else begin
      rsp_q.push_back({1'b1, 32'd0});
    end
  endtask

  task automatic accept_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    bit acc = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_a_i = a;
    cmd_b_i = b;
    cmd_op_i = op;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready_o) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("cmd_accept", 65'(acc), 65'd1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cmd_a_i = 16'hFFFF;
    cmd_b_i = 16'hFFFF;
    cmd_op_i = 3'd7;
  endtask

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input int hold, input bit lat_chk, input bit spur_resp);
    bit got = 1'b0;
    logic [32:0] e;
    accept_cmd(a, b, op);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (lat_chk && i == 8) check_eq("lat_cycle8_idle", 65'(rsp_valid_o), 65'd0);
      if (rsp_valid_o) begin
        got = 1'b1;
        if (lat_chk) check_eq("lat_cycle9", 65'(i), 65'd9);
        break;
      end
    end
    check_eq("rsp_arrived", 65'(got), 65'd1);
    e = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'h1_FFFF_FFFF;
    check_eq("rsp_data", 65'(rsp_data_o), 65'(e[31:0]));
    check_eq("rsp_err", 65'(rsp_err_o), 65'(e[32]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      spur_rv = spur_resp && (h == 1);
      check_eq("hold_stable", {30'd0, rsp_valid_o, cmd_ready_o, rsp_err_o, rsp_data_o},
               {30'd0, 1'b1, 1'b0, e[32], e[31:0]});
    end
    @(negedge clk);
    spur_rv = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rsp", {63'd0, rsp_valid_o, cmd_ready_o}, {63'd0, 1'b0, 1'b1});
    check_eq("bus_all_seen", 65'(bus_q.size()), 65'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {rsp_err_o, rsp_valid_o, cmd_ready_o, conv_req_o, conv_we_o,
                            conv_be_o, rsp_data_o, conv_addr_o | conv_wdata_o},
             65'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // ADD with latency check
    slv_rdval = 32'h0000_5400;
    expect_cmd(16'h4000, 16'h4800, 3'd1, slv_rdval);
    send_cmd(16'h4000, 16'h4800, 3'd1, 0, 1'b1, 1'b0);

    // Backpressure on the response
    slv_rdval = 32'h0000_5400;
    expect_cmd(16'h4000, 16'h4800, 3'd1, slv_rdval);
    send_cmd(16'h4000, 16'h4800, 3'd1, 5, 1'b0, 1'b0);

    // Illegal opcodes produce an error with no bus traffic
    rc = req_cnt;
    expect_cmd(16'h1234, 16'h5678, 3'd0, 32'd0);
    send_cmd(16'h1234, 16'h5678, 3'd0, 0, 1'b0, 1'b0);
    expect_cmd(16'h1234, 16'h5678, 3'd5, 32'd0);
    send_cmd(16'h1234, 16'h5678, 3'd5, 1, 1'b0, 1'b0);
    check_eq("illegal_no_req", 65'(req_cnt - rc), 65'd0);

    // Slow slave with spurious rvalid in IDLE and RESP
    slv_delay = 3;
    slv_rdval = 32'h0000_4B00;
    @(negedge clk);
    spur_rv = 1'b1;
    @(negedge clk);
    spur_rv = 1'b0;
    expect_cmd(16'h3C00, 16'h4200, 3'd2, slv_rdval);
    send_cmd(16'h3C00, 16'h4200, 3'd2, 3, 1'b0, 1'b1);
    slv_delay = 0;

    // DIV with a different read value
    slv_rdval = 32'hA5A5_3C01;
    expect_cmd(16'h7FFF, 16'h0001, 3'd3, slv_rdval);
    send_cmd(16'h7FFF, 16'h0001, 3'd3, 0, 1'b1, 1'b0);

    // Reset while waiting for the WR_B response
    expect_cmd(16'h4400, 16'h4600, 3'd1, 32'd0);
    accept_cmd(16'h4400, 16'h4600, 3'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (conv_req_o && conv_we_o && conv_addr_o == 32'd8) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("reach_wr_b", 65'(seen), 65'd1);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("reset_mid_outs", {rsp_err_o, rsp_valid_o, cmd_ready_o, conv_req_o, conv_we_o,
                                conv_be_o, rsp_data_o, conv_addr_o | conv_wdata_o},
             65'd0);
    bus_q.delete();
    rsp_q.delete();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1'b1;
    end
    check_eq("no_rsp_after_reset", 65'(seen), 65'd0);
    slv_rdval = 32'h0000_4F00;
    expect_cmd(16'h4400, 16'h4600, 3'd1, slv_rdval);
    send_cmd(16'h4400, 16'h4600, 3'd1, 0, 1'b1, 1'b0);

`ifdef POSIT_COP_MASTER_TIMEOUT_EN
    // Slave never answers WR_OP; late rvalid during RESP must be ignored
    drop_op = 1'b1;
    bus_q.push_back({1'b1, 32'd0,  32'h0000_4000});
    bus_q.push_back({1'b1, 32'd8,  32'h0000_4400});
    bus_q.push_back({1'b1, 32'd16, 32'd2});
    rsp_q.push_back({1'b1, 32'hDEAD_0002});
    send_cmd(16'h4000, 16'h4400, 3'd2, 3, 1'b0, 1'b1);
    drop_op = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
